// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit ripple adder/subtractor split into STAGES chunks, one chunk per cycle,
// with a global valid/ready stall so the downstream normaliser can hold the whole pipe.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = WIDTH / STAGES;
  logic advance;
  logic ov_d, ov_q;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i, b_i, s_i, a_d, a_q, b_d, b_q, s_d, s_q;
    logic c_i, v_i, c_d, c_q, v_d, v_q;
    logic [CW:0] cy;
    if (k == 0) begin : g_src
      always_comb begin
        a_i = a;
        b_i = b ^ {WIDTH{sub}};
        s_i = '0;
        c_i = cin ^ sub;
        v_i = in_valid;
      end
    end else begin : g_src
      always_comb begin
        a_i = g_stage[k-1].a_q;
        b_i = g_stage[k-1].b_q;
        s_i = g_stage[k-1].s_q;
        c_i = g_stage[k-1].c_q;
        v_i = g_stage[k-1].v_q;
      end
    end
    // Operands travel whole so upper chunks stay aligned; finished lower sum chunks ride along.
    always_comb begin
      s_d   = s_i;
      cy[0] = c_i;
      for (int j = 0; j < CW; j++) begin
        s_d[k*CW+j] = a_i[k*CW+j] ^ b_i[k*CW+j] ^ cy[j];
        cy[j+1]     = (a_i[k*CW+j] & b_i[k*CW+j]) | (cy[j] & (a_i[k*CW+j] ^ b_i[k*CW+j]));
      end
      a_d = a_i;
      b_d = b_i;
      c_d = cy[CW];
      v_d = v_i;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (advance) begin
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end
    if (k == STAGES - 1) begin : g_sink
      logic unused_ab;
      always_comb unused_ab = ^{a_q, b_q};
    end
  end
  always_comb begin
    out_valid = g_stage[STAGES-1].v_q;
    sum       = g_stage[STAGES-1].s_q;
    cout      = g_stage[STAGES-1].c_q;
    overflow  = ov_q;
    advance   = !out_valid || out_ready;
    in_ready  = advance;
    ov_d      = g_stage[STAGES-1].cy[CW] ^ g_stage[STAGES-1].cy[CW-1];
  end
  always_ff @(posedge clk) begin
    if (rst) ov_q <= 1'b0;
    else if (advance) ov_q <= ov_d;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor: the WIDTH-bit successor of the single-bit gate-level full adder. It splits the operands into STAGES equal chunks and forms one chunk's ripple sum per cycle. The carry is registered between chunks. It sits in the FMA datapath as the final mantissa add stage. A valid/ready handshake lets the normaliser downstream stall it.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block will accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry/borrow-in.
- sub  input  1  0: A+B+cin; 1: A+~B+~cin (A-B-cin).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Operands are transformed on entry:
  - effective B = b XOR {WIDTH{sub}};
  - effective carry-in = cin XOR sub.
- Stage k (k = 0..STAGES-1) adds chunk k, bits [k*CW +: CW], of A and effective B.
  - Its carry-in is stage k-1's registered carry; stage 0 uses the effective carry-in.
  - Each chunk is a ripple of full-adder cells.
- Skew: unused upper chunks travel with the transaction. Completed lower result chunks are carried forward, so all bits of one transaction exit together.
- Each stage holds a valid bit. The pipeline carries no other state machine.
- Global advance:
  - advance = !out_valid || out_ready;
  - in_ready = advance;
  - when advance, every stage shifts one step and stage 0 loads (in_valid & in_ready).
- Bubbles are not collapsed. An empty stage shifts like a full one.
- Transactions are never reordered, dropped or duplicated.
- overflow is computed in the last stage from the carry into and out of bit WIDTH-1.
- STAGES=1 is a single registered adder.

## Timing
- Reset, with rst high at an edge:
  - all valid bits 0 and all data/carry registers 0;
  - outputs become out_valid=0, sum=0, cout=0, overflow=0;
  - in_ready=1 from the following cycle.
- Reset mid-operation discards all in-flight transactions. None emerges afterwards.
- Reset has priority over a simultaneous in_valid.
- Latency: a transaction accepted at edge t (in_valid & in_ready) shows out_valid=1 after edge t+STAGES-1, i.e. STAGES edges including the accepting edge, when there are no stalls.
- Throughput: one result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - in_ready=0;
  - all stage registers hold;
  - sum, cout and overflow stay stable.
- A result is consumed at an edge where out_valid & out_ready. In the same cycle a new input may be accepted.
- in_valid with in_ready=0 is ignored. The source must hold its operands.
- The carry path is combinational only within a CW-bit chunk. No combinational path runs from in_valid or out_ready to sum.
- in_ready depends combinationally on out_ready.

## Test plan
All scenarios use WIDTH=32, STAGES=4.
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 after release; no output emerges.
- Full carry ripple: a=FFFFFFFF, b=00000001, cin=0, sub=0, out_ready=1 -> sum=00000000, cout=1, overflow=0, with out_valid high exactly 4 edges after acceptance.
- Signed cases:
  - a=7FFFFFFF, b=1 -> sum=80000000, cout=0, overflow=1;
  - a=5, b=7, sub=1 -> sum=FFFFFFFE, cout=0, overflow=0;
  - a=7, b=5, sub=1, cin=1 -> sum=00000001, cout=1.
- Streaming: 16 back-to-back random transactions with out_ready=1 -> one result per cycle in input order, each matching a reference model of a+b+cin / a-b-cin mod 2^32.
- Backpressure: fill the pipeline, then drop out_ready for 3 cycles -> in_ready=0, outputs frozen; on release all results appear in order, none lost or duplicated.
- Reset mid-flight: assert rst for 1 cycle with 3 transactions in flight -> out_valid=0 next cycle; a fresh transaction then emerges with normal 4-cycle latency.
